// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store merge path: size codes, FSM encoding and
// big-endian byte-lane selection helpers.
package store_merge_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Lane mask bit 3 is bits [31:24], i.e. byte offset 0 (big-endian).
    localparam int         NUM_LANES     = 4;
    localparam logic [3:0] LANES_NONE    = 4'b0000;
    localparam logic [3:0] LANE_BYTE0    = 4'b1000;
    localparam logic [3:0] LANES_HI_HALF = 4'b1100;
    localparam logic [3:0] LANES_LO_HALF = 4'b0011;
    localparam logic [3:0] LANES_ALL     = 4'b1111;

    function automatic logic [3:0] lane_select(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] sel;
        sel = LANES_NONE;
        case (size)
            SZ_BYTE: sel = LANE_BYTE0 >> offset;
            SZ_HALF: sel = offset[1] ? LANES_LO_HALF : LANES_HI_HALF;
            SZ_WORD: sel = LANES_ALL;
            default: sel = LANES_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic req_legal(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~offset[0];
            SZ_WORD: ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_merge_unit_byte_lane_merge.sv
// Combinational lane merge: replaces the addressed byte/half/word lanes of an
// old memory word with the low bits of the new store data.
module byte_lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged
);

    logic [3:0]  lane_en;
    logic [31:0] repl;

    assign lane_en = lane_select(size, offset);

    // Replicate the store data so every lane already holds the right bytes.
    always_comb begin
        repl = new_data;
        case (size)
            SZ_BYTE: repl = {4{new_data[7:0]}};
            SZ_HALF: repl = {2{new_data[15:0]}};
            default: repl = new_data;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = lane_en[gi] ? repl[gi*8 +: 8] : old_word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/store_merge_unit.sv
// Store path: narrows register data to byte/half/word and writes it to a
// word-wide memory, using read-modify-write for sub-word stores.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-3:0] word_addr_reg;
    logic [1:0]        offset_reg;
    logic [1:0]        size_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       merge_reg;
    logic [31:0]       merged_word;
    logic              load_req;

    assign load_req = (state_reg == ST_IDLE) && req && req_legal(size, addr[1:0]);

    byte_lane_merge u_merge (
        .old_word (mem_rdata),
        .new_data (wdata_reg),
        .size     (size_reg),
        .offset   (offset_reg),
        .merged   (merged_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != ST_IDLE);
        done       = 1'b0;
        err        = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    if (!req_legal(size, addr[1:0])) begin
                        state_next = ST_ERR;
                    end else if (size == SZ_WORD) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                if (mem_ready) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                err        = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Word stores preload the merge register so WRITE can follow IDLE directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_addr_reg <= '0;
            offset_reg    <= 2'b00;
            size_reg      <= SZ_BYTE;
            wdata_reg     <= 32'h0;
            merge_reg     <= 32'h0;
        end else if (load_req) begin
            word_addr_reg <= addr[ADDR_W-1:2];
            offset_reg    <= addr[1:0];
            size_reg      <= size;
            wdata_reg     <= wdata;
            merge_reg     <= wdata;
        end else if ((state_reg == ST_READ) && mem_ready) begin
            merge_reg     <= merged_word;
        end
    end

    assign mem_addr  = word_addr_reg;
    assign mem_wdata = merge_reg;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: a cycle-timeline model plus a wait-state
// memory responder, checked every cycle on the falling edge.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [1:0]  size = 2'b00;
    logic        busy, done, err, mem_re, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .addr      (addr),
        .wdata     (wdata),
        .size      (size),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        bit          re;
        bit          we;
        bit          done;
        bit          err;
        bit          chk_addr;
        bit          chk_wdata;
        logic [29:0] maddr;
        logic [31:0] mwdata;
    } rec_t;

    rec_t        exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] mem [int];
    int          rd_waits = 0;
    int          wr_waits = 0;
    int          writes = 0;
    int          reads = 0;

    function automatic rec_t idle_rec();
        rec_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(input int a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Expected memory word after a store, from shift/mask arithmetic.
    function automatic logic [31:0] model_merge(input logic [31:0] oldw, input logic [31:0] d,
                                                input logic [1:0] sz, input logic [1:0] off);
        int sh;
        if (sz == 2'b00) begin
            sh = (3 - int'(off)) * 8;
            return (oldw & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end else if (sz == 2'b01) begin
            sh = off[1] ? 0 : 16;
            return (oldw & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        compared++;
        if (act !== req_v) begin
            mismatched++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req_v);
        end
    endtask

    // Memory responder: each access waits rd_waits/wr_waits cycles before mem_ready.
    initial begin
        int ctr;
        int lim;
        ctr = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || !(mem_re || mem_we)) begin
                ctr = 0;
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0BAD0;
            end else begin
                lim = mem_re ? rd_waits : wr_waits;
                if (ctr >= lim) begin
                    ctr = 0;
                    mem_ready = 1'b1;
                    if (mem_re) begin
                        mem_rdata = mem_rd(int'(mem_addr));
                        reads++;
                    end else begin
                        mem[int'(mem_addr)] = mem_wdata;
                        writes++;
                    end
                end else begin
                    ctr++;
                    mem_ready = 1'b0;
                    mem_rdata = 32'hBAD0BAD0;
                end
            end
        end
    end

    // Per-cycle comparison against the expected timeline (idle when empty).
    initial begin
        forever begin
            rec_t r;
            @(negedge clk);
            if (reset) begin
                r = idle_rec();
                r.chk_addr = 1'b1;
                r.chk_wdata = 1'b1;
            end else if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
            end else begin
                r = idle_rec();
            end
            check("busy", {31'b0, busy}, {31'b0, r.busy});
            check("mem_re", {31'b0, mem_re}, {31'b0, r.re});
            check("mem_we", {31'b0, mem_we}, {31'b0, r.we});
            check("done", {31'b0, done}, {31'b0, r.done});
            check("err", {31'b0, err}, {31'b0, r.err});
            if (r.chk_addr) check("mem_addr", {2'b0, mem_addr}, {2'b0, r.maddr});
            if (r.chk_wdata) check("mem_wdata", mem_wdata, r.mwdata);
        end
    end

    // Called in an IDLE cycle (cycle 0); returns in the IDLE cycle after done/err.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input int rw, input int ww, input bit noise, output int done_cyc);
        rec_t        r;
        int          len;
        logic [29:0] wa;
        logic [31:0] neww;
        bit          legal;
        wa = a[31:2];
        legal = (sz == 2'b00) || (sz == 2'b01 && a[0] == 1'b0) || (sz == 2'b10 && a[1:0] == 2'b00);
        rd_waits = rw;
        wr_waits = ww;
        size = sz;
        addr = a;
        wdata = d;
        req = 1'b1;
        exp_q.push_back(idle_rec());
        len = 0;
        if (!legal) begin
            r = idle_rec();
            r.busy = 1'b1;
            r.err = 1'b1;
            exp_q.push_back(r);
            len = 1;
        end else begin
            neww = model_merge(mem_rd(int'(wa)), d, sz, a[1:0]);
            if (sz != 2'b10) begin
                for (int i = 0; i <= rw; i++) begin
                    r = idle_rec();
                    r.busy = 1'b1;
                    r.re = 1'b1;
                    r.chk_addr = 1'b1;
                    r.maddr = wa;
                    exp_q.push_back(r);
                    len++;
                end
            end
            for (int i = 0; i <= ww; i++) begin
                r = idle_rec();
                r.busy = 1'b1;
                r.we = 1'b1;
                r.chk_addr = 1'b1;
                r.maddr = wa;
                r.chk_wdata = 1'b1;
                r.mwdata = neww;
                exp_q.push_back(r);
                len++;
            end
            r = idle_rec();
            r.busy = 1'b1;
            r.done = 1'b1;
            exp_q.push_back(r);
            len++;
        end
        done_cyc = len;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk);
            #2;
            req = noise && (k >= 2) && (k < len);
            if (req) addr = 32'h400;
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int w0;
        int r0;

        check("model_byte", model_merge(32'h11223344, 32'hFFFFFFAB, 2'b00, 2'd2), 32'h1122AB44);
        check("model_half", model_merge(32'hAAAABBBB, 32'h00001234, 2'b01, 2'd0), 32'h1234BBBB);
        check("model_byte3", model_merge(32'h01020304, 32'h0000005A, 2'b00, 2'd3), 32'h0102035A);

        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;

        // Word store, mem_ready effectively tied high
        r0 = reads;
        do_store(2'b10, 32'h100, 32'hDEADBEEF, 0, 0, 1'b0, dc);
        check("word_done_cycle", dc, 2);
        check("word_mem", mem_rd(32'h40), 32'hDEADBEEF);
        check("word_no_read", reads, r0);

        // Byte store at offset 2
        mem[32'h40] = 32'h11223344;
        do_store(2'b00, 32'h102, 32'hFFFFFFAB, 0, 0, 1'b0, dc);
        check("byte_done_cycle", dc, 3);
        check("byte_mem", mem_rd(32'h40), 32'h1122AB44);

        // Halfword at offset 0 with two wait states on read and write
        mem[32'h80] = 32'hAAAABBBB;
        do_store(2'b01, 32'h200, 32'h00001234, 2, 2, 1'b0, dc);
        check("half_done_cycle", dc, 7);
        check("half_mem", mem_rd(32'h80), 32'h1234BBBB);

        // Misaligned and illegal requests never touch memory
        w0 = writes;
        r0 = reads;
        do_store(2'b01, 32'h3, 32'h1, 0, 0, 1'b0, dc);
        check("err_half_cycle", dc, 1);
        do_store(2'b10, 32'h2, 32'h2, 0, 0, 1'b0, dc);
        check("err_word_cycle", dc, 1);
        do_store(2'b11, 32'h0, 32'h3, 0, 0, 1'b0, dc);
        check("err_size_cycle", dc, 1);
        check("err_no_write", writes, w0);
        check("err_no_read", reads, r0);

        // req raised during WRITE waits is ignored
        w0 = writes;
        do_store(2'b10, 32'h300, 32'h0BADF00D, 0, 2, 1'b1, dc);
        check("noise_done_cycle", dc, 4);
        check("noise_one_write", writes, w0 + 1);
        check("noise_mem", mem_rd(32'hC0), 32'h0BADF00D);
        check("noise_other_untouched", {31'b0, mem.exists(32'h100)}, 32'h0);

        // Additional lane positions
        mem[32'h1C0] = 32'h01020304;
        do_store(2'b00, 32'h703, 32'h0000005A, 1, 0, 1'b0, dc);
        check("byte3_mem", mem_rd(32'h1C0), 32'h0102035A);
        mem[32'h200] = 32'h11112222;
        do_store(2'b01, 32'h802, 32'h0000BEEF, 0, 1, 1'b0, dc);
        check("half2_mem", mem_rd(32'h200), 32'h1111BEEF);

        // Reset asserted mid-READ while waiting on mem_ready
        w0 = writes;
        r0 = reads;
        rd_waits = 5;
        size = 2'b00;
        addr = 32'h501;
        wdata = 32'h77;
        req = 1'b1;
        exp_q.push_back(idle_rec());
        begin
            rec_t rr;
            rr = idle_rec();
            rr.busy = 1'b1;
            rr.re = 1'b1;
            rr.chk_addr = 1'b1;
            rr.maddr = 30'h140;
            exp_q.push_back(rr);
        end
        @(posedge clk);
        #2;
        req = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_re", {31'b0, mem_re}, 32'h0);
        check("rst_we", {31'b0, mem_we}, 32'h0);
        check("rst_addr", {2'b0, mem_addr}, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        check("rst_no_write", writes, w0);
        check("rst_no_read", reads, r0);

        do_store(2'b10, 32'h600, 32'hCAFEF00D, 0, 0, 1'b0, dc);
        check("post_rst_mem", mem_rd(32'h180), 32'hCAFEF00D);
        check("post_rst_aborted_word", mem_rd(32'h140), 32'h0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-path partner of the datapath's immediate/load extension logic: it narrows a 32-bit register value to a byte, halfword or word and writes it into word-organised data memory. Sub-word stores use a read-modify-write sequence, so only the addressed lanes change. It sits between the EX/MEM store request and the word-wide data memory port.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; memory is word-addressed using addr[ADDR_W-1:2].

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  1  store request; sampled only in IDLE.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data; the value is taken from the low bits (byte = [7:0], half = [15:0]).
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the store completes.
- err  out  1  one-cycle pulse on a misaligned or illegal request.
- mem_addr  out  ADDR_W-2  word address.
- mem_re  out  1  read strobe; held until mem_ready.
- mem_we  out  1  write strobe; held until mem_ready.
- mem_wdata  out  32  merged write word.
- mem_rdata  in  32  read word; valid in the cycle mem_ready is high during READ.
- mem_ready  in  1  memory completes the current access.

## Operation
- Byte lanes are big-endian: offset 0 maps to [31:24], 1 to [23:16], 2 to [15:8] and 3 to [7:0]. Halfword offset 0 maps to [31:16] and offset 2 to [15:0].
- Request checks in IDLE with req=1:
  - size=11: illegal.
  - half with addr[0]=1: misaligned.
  - word with addr[1:0]≠0: misaligned.
  - On any of these, go to ERR. Memory is never touched.
- The FSM has the states IDLE, READ, WRITE, DONE and ERR.
- IDLE: on an accepted request, latch addr, wdata and size.
  - A word store goes to WRITE.
  - A byte or half store goes to READ.
- READ: mem_re=1 and mem_addr is the latched word address.
  - On mem_ready, capture mem_rdata into the merge register.
  - Then go to WRITE.
- WRITE: mem_we=1 and mem_wdata = merged word.
  - A word store writes wdata unchanged.
  - A sub-word store replaces only the addressed lane(s) of the captured word.
  - On mem_ready, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE.
- req while busy is ignored and not queued. The requester must hold req until it sees done or err, or re-issue the request afterwards.
- mem_re and mem_we are never asserted together.

## Timing
- All outputs are registered or decoded from state only, with no combinational path from req to memory strobes.
- Reset (asynchronous) forces IDLE and sets busy, done, err, mem_re and mem_we to 0, with mem_addr and mem_wdata = 0. Any in-flight access is abandoned.
- Word store with mem_ready tied high:
  - Request accepted at edge 0.
  - mem_we is high in cycle 1.
  - done is high in cycle 2.
  - Total latency: 2 cycles.
- Sub-word store with zero wait states:
  - READ in cycle 1.
  - WRITE in cycle 2.
  - done in cycle 3.
- Each mem_ready wait cycle adds exactly one cycle.
- Error path: err is high in cycle 1 and busy is high in cycle 1 only.
- The unit is back in IDLE in the cycle after done or err, so a new req is accepted on that edge. Maximum throughput is one word store per 3 cycles.
- mem_addr is stable for the whole READ→WRITE sequence.

## Structure
- Shared package:
  - size codes (SZ_BYTE, SZ_HALF, SZ_WORD);
  - FSM state encoding (3 bits);
  - lane-select constants.
- One combinational sub-module, byte_lane_merge, with inputs old word, new data, size and offset[1:0], and output merged word. It is verified standalone.
- The FSM, latch registers and memory strobes stay in store_merge_unit.

## Test plan
- Word store, mem_ready=1: addr 0x100, wdata 0xDEADBEEF → mem_we in cycle 1 with mem_addr 0x40 and mem_wdata 0xDEADBEEF; done in cycle 2; mem_re never asserted.
- Byte store: memory word 0x11223344, addr 0x0000_0102, wdata 0xFFFF_FFAB → READ then WRITE with mem_wdata 0x1122AB44; done in cycle 3.
- Halfword store at offset 0 with 2 wait states on both the read and the write: old word 0xAAAABBBB, wdata 0x1234 → mem_wdata 0x1234BBBB; done in cycle 7; strobes held through the waits.
- Misaligned and illegal requests: half at addr 0x3, word at addr 0x2, size=11 → each gives an err pulse in cycle 1, no mem_re/mem_we, and IDLE in cycle 2.
- req re-asserted during a WRITE wait is ignored: only one write occurs. A new req on the cycle after done is accepted.
- Reset asserted mid-READ while waiting on mem_ready → all outputs 0 immediately. After release, a word store completes normally with no stale merge data.
